memory_dual_port: RTL and testbench
===================================

MEMORY_DUAL_PORT -- requirements
Module: memory_dual_port

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits (integer multiple of BYTE_WIDTH).
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 10, depth = 2**ADDRESS_WIDTH words.
REQ-003 The block SHALL have parameter BYTE_WIDTH, default 8, lane width for byte enables; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-004 The block SHALL have parameter OUT_REG, default 0, 1 adds an output register stage.
REQ-005 The block SHALL have parameter RDW_MODE, default 0, same-address cross-port read-during-write result: 0 = old data, 1 = new data.
REQ-006 The block SHALL have parameter CLEAR_ON_RESET, default 1, 1 = fill memory with INIT_VALUE after reset.
REQ-007 The block SHALL have parameter INIT_VALUE, default 0, clear fill word.
REQ-008 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-009 Ports: clk  input  1  rising-edge clock.
REQ-010 Ports: rst_n  input  1  asynchronous active-low reset.
REQ-011 Ports: a_en, b_en  input  1  port access request.
REQ-012 Ports: a_write, b_write  input  1  1 = write, 0 = read (qualified by en).
REQ-013 Ports: a_byte_en, b_byte_en  input  NB  per-lane write enable.
REQ-014 Ports: a_addr, b_addr  input  ADDRESS_WIDTH  word address.
REQ-015 Ports: a_data_in, b_data_in  input  DATA_WIDTH  write data.
REQ-016 Ports: a_data_out, b_data_out  output  DATA_WIDTH  read data.
REQ-017 Ports: a_valid, b_valid  output  1  read data valid strobe.
REQ-018 Ports: ready  output  1  clear complete, accesses accepted.
REQ-019 Ports: collision  output  1  one-cycle pulse on same-address double write.

Function
REQ-020 An access SHALL be accepted on a rising clk edge when en=1 and ready=1; accesses while ready=0 SHALL be ignored without effect.
REQ-021 A write SHALL update only lanes whose byte_en bit is 1; other lanes keep their value.
REQ-022 A read SHALL return data with x_valid=1 exactly 1 cycle after acceptance (OUT_REG=0) or 2 cycles (OUT_REG=1); x_valid is 0 in all other cycles.
REQ-023 data_out SHALL hold its last value while valid=0; writes SHALL NOT assert valid.
REQ-024 Same-port write SHALL NOT produce read data (write-only cycle).
REQ-025 Both ports writing the same address in one cycle: port A lanes SHALL win on overlapping lanes, B-only lanes written from B, collision=1 for the following cycle.
REQ-026 One port writing, other reading same address in one cycle: reader SHALL get pre-write word if RDW_MODE=0, post-write merged word if RDW_MODE=1.
REQ-027 Accesses to different addresses SHALL be fully independent and concurrent.
REQ-028 Clear FSM states: CLEAR, RUN. With CLEAR_ON_RESET=1 the FSM SHALL enter CLEAR on reset, write INIT_VALUE at address 0 on the first edge after rst_n release, increment by 1 per cycle, and move to RUN after writing address 2**ADDRESS_WIDTH-1 (counter does not wrap past it).
REQ-029 ready SHALL be 1 exactly in RUN; with CLEAR_ON_RESET=1 it rises 2**ADDRESS_WIDTH cycles after the first edge following reset release; with CLEAR_ON_RESET=0 the FSM SHALL enter RUN on the first edge after release.
REQ-030 Reads pending in the output pipeline when ready falls SHALL be discarded (valid not asserted).

Reset
REQ-031 Assertion of rst_n=0 SHALL immediately force a_data_out=0, b_data_out=0, a_valid=0, b_valid=0, ready=0, collision=0, clear counter=0, state=CLEAR (or RUN-pending when CLEAR_ON_RESET=0).
REQ-032 Reset asserted mid-clear or mid-operation SHALL restart the clear from address 0; memory contents are not reset asynchronously.

Verification
REQ-033 Clear: AW=4, CLEAR_ON_RESET=1, INIT_VALUE=8'hA5, release reset -> ready rises after 16 cycles; read all 16 addresses on A -> every word 8'hA5.
REQ-034 Byte enable: DW=32, write 32'h11223344 addr 5, then write 32'hAABBCCDD byte_en=4'b0101 -> read addr 5 returns 32'h11BB33DD, valid 1 cycle later (2 with OUT_REG=1).
REQ-035 Double write: A writes 8'h12, B writes 8'h34 to addr 3 same cycle -> collision=1 next cycle only; later read addr 3 = 8'h12.
REQ-036 Read-during-write: addr 7 holds 8'h00; A writes 8'hFF, B reads addr 7 same cycle -> b_data_out=8'h00 (RDW_MODE=0) or 8'hFF (RDW_MODE=1).
REQ-037 Reset mid-clear: pulse rst_n low at clear address 9, release -> ready stays 0 for full 2**ADDRESS_WIDTH cycles; requests issued meanwhile produce no valid and no memory change.

Source files
------------

// File: rtl/memory_dual_port.sv
// rtl/memory_dual_port.sv - true dual-port RAM with byte enables, optional output register and post-reset clear
module memory_dual_port #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDRESS_WIDTH  = 10,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    OUT_REG        = 0,
  parameter int                    RDW_MODE       = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               a_en,
  input  logic                               a_write,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   a_byte_en,
  input  logic [ADDRESS_WIDTH-1:0]           a_addr,
  input  logic [DATA_WIDTH-1:0]              a_data_in,
  output logic [DATA_WIDTH-1:0]              a_data_out,
  output logic                               a_valid,
  input  logic                               b_en,
  input  logic                               b_write,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   b_byte_en,
  input  logic [ADDRESS_WIDTH-1:0]           b_addr,
  input  logic [DATA_WIDTH-1:0]              b_data_in,
  output logic [DATA_WIDTH-1:0]              b_data_out,
  output logic                               b_valid,
  output logic                               ready,
  output logic                               collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                       clr_wr;
  logic [DATA_WIDTH-1:0]      mem_q [DEPTH];

  logic                       a_wr, a_rd, b_wr, b_rd, same_addr;
  logic [NB-1:0]              a_lane_we, b_lane_we;
  logic [DATA_WIDTH-1:0]      a_rword, b_rword;

  logic                       a_v1_q, a_v1_d, b_v1_q, b_v1_d;
  logic [DATA_WIDTH-1:0]      a_d1_q, a_d1_d, b_d1_q, b_d1_d;
  logic                       collision_q, collision_d;

  assign ready     = (state_q == RUN);
  assign collision = collision_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_wr    = 1'b0;
    if (state_q == CLEAR) begin
      if (CLEAR_ON_RESET != 0) begin
        clr_wr = 1'b1;
        // Counter parks on the last address instead of wrapping.
        if (clr_cnt_q == {ADDRESS_WIDTH{1'b1}}) state_d = RUN;
        else clr_cnt_d = clr_cnt_q + 1'b1;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_comb begin
    a_wr      = a_en & a_write & ready;
    a_rd      = a_en & ~a_write & ready;
    b_wr      = b_en & b_write & ready;
    b_rd      = b_en & ~b_write & ready;
    same_addr = (a_addr == b_addr);
    a_rword   = mem_q[a_addr];
    b_rword   = mem_q[b_addr];
    for (int l = 0; l < NB; l++) begin
      a_lane_we[l] = a_wr & a_byte_en[l];
      // Port A owns any lane both ports write at the same address.
      b_lane_we[l] = b_wr & b_byte_en[l] & ~(a_wr & same_addr & a_byte_en[l]);
      if (RDW_MODE != 0 && same_addr && b_lane_we[l])
        a_rword[l*BYTE_WIDTH +: BYTE_WIDTH] = b_data_in[l*BYTE_WIDTH +: BYTE_WIDTH];
      if (RDW_MODE != 0 && same_addr && a_lane_we[l])
        b_rword[l*BYTE_WIDTH +: BYTE_WIDTH] = a_data_in[l*BYTE_WIDTH +: BYTE_WIDTH];
    end
    a_v1_d      = a_rd;
    b_v1_d      = b_rd;
    a_d1_d      = a_rd ? a_rword : a_d1_q;
    b_d1_d      = b_rd ? b_rword : b_d1_q;
    collision_d = a_wr & b_wr & same_addr;
  end

  // Array contents survive reset; only the clear sweep rewrites them.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem_q[clr_cnt_q] <= INIT_VALUE;
    end else begin
      for (int l = 0; l < NB; l++) begin
        if (a_lane_we[l])
          mem_q[a_addr][l*BYTE_WIDTH +: BYTE_WIDTH] <= a_data_in[l*BYTE_WIDTH +: BYTE_WIDTH];
        if (b_lane_we[l])
          mem_q[b_addr][l*BYTE_WIDTH +: BYTE_WIDTH] <= b_data_in[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      a_v1_q      <= 1'b0;
      b_v1_q      <= 1'b0;
      a_d1_q      <= '0;
      b_d1_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      a_v1_q      <= a_v1_d;
      b_v1_q      <= b_v1_d;
      a_d1_q      <= a_d1_d;
      b_d1_q      <= b_d1_d;
      collision_q <= collision_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  a_v2_q, a_v2_d, b_v2_q, b_v2_d;
    logic [DATA_WIDTH-1:0] a_d2_q, a_d2_d, b_d2_q, b_d2_d;

    always_comb begin
      a_v2_d = a_v1_q & ready;
      b_v2_d = b_v1_q & ready;
      a_d2_d = a_v2_d ? a_d1_q : a_d2_q;
      b_d2_d = b_v2_d ? b_d1_q : b_d2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v2_d;
        b_v2_q <= b_v2_d;
        a_d2_q <= a_d2_d;
        b_d2_q <= b_d2_d;
      end
    end

    assign a_valid    = a_v2_q;
    assign b_valid    = b_v2_q;
    assign a_data_out = a_d2_q;
    assign b_data_out = b_d2_q;
  end else begin : g_no_out_reg
    assign a_valid    = a_v1_q;
    assign b_valid    = b_v1_q;
    assign a_data_out = a_d1_q;
    assign b_data_out = b_d1_q;
  end

endmodule

// File: tb/tb_memory_dual_port.sv
// tb/tb_memory_dual_port.sv - directed bench: two instances (old-data/no out reg, new-data/out reg)
module tb_memory_dual_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_write, b_en, b_write;
  logic [3:0]  a_byte_en, b_byte_en;
  logic [3:0]  a_addr, b_addr;
  logic [31:0] a_data_in, b_data_in;
  logic [31:0] a_do1, b_do1, a_do2, b_do2;
  logic        a_v1, b_v1, a_v2, b_v2, rdy1, rdy2, col1, col2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_dual_port #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8), .OUT_REG(0), .RDW_MODE(0),
    .CLEAR_ON_RESET(1), .INIT_VALUE(32'hA5A5_A5A5)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_write(a_write), .a_byte_en(a_byte_en), .a_addr(a_addr),
    .a_data_in(a_data_in), .a_data_out(a_do1), .a_valid(a_v1),
    .b_en(b_en), .b_write(b_write), .b_byte_en(b_byte_en), .b_addr(b_addr),
    .b_data_in(b_data_in), .b_data_out(b_do1), .b_valid(b_v1),
    .ready(rdy1), .collision(col1)
  );

  memory_dual_port #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8), .OUT_REG(1), .RDW_MODE(1),
    .CLEAR_ON_RESET(1), .INIT_VALUE(32'hA5A5_A5A5)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_write(a_write), .a_byte_en(a_byte_en), .a_addr(a_addr),
    .a_data_in(a_data_in), .a_data_out(a_do2), .a_valid(a_v2),
    .b_en(b_en), .b_write(b_write), .b_byte_en(b_byte_en), .b_addr(b_addr),
    .b_data_in(b_data_in), .b_data_out(b_do2), .b_valid(b_v2),
    .ready(rdy2), .collision(col2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic en, input logic wr, input logic [3:0] be,
                       input logic [3:0] addr, input logic [31:0] data);
    a_en = en; a_write = wr; a_byte_en = be; a_addr = addr; a_data_in = data;
  endtask

  task automatic set_b(input logic en, input logic wr, input logic [3:0] be,
                       input logic [3:0] addr, input logic [31:0] data);
    b_en = en; b_write = wr; b_byte_en = be; b_addr = addr; b_data_in = data;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // Issue one read; dut1 answers one cycle later, dut2 two cycles later.
  task automatic rd(input string tag, input bit port_b, input logic [3:0] addr,
                    input logic [31:0] exp1, input logic [31:0] exp2);
    @(negedge clk);
    if (port_b) set_b(1'b1, 1'b0, 4'h0, addr, 32'h0);
    else        set_a(1'b1, 1'b0, 4'h0, addr, 32'h0);
    @(negedge clk);
    idle();
    chk({tag, " v1"}, port_b ? b_v1 : a_v1, 1);
    chk({tag, " d1"}, port_b ? b_do1 : a_do1, exp1);
    chk({tag, " v2 early"}, port_b ? b_v2 : a_v2, 0);
    @(negedge clk);
    chk({tag, " v1 drop"}, port_b ? b_v1 : a_v1, 0);
    chk({tag, " v2"}, port_b ? b_v2 : a_v2, 1);
    chk({tag, " d2"}, port_b ? b_do2 : a_do2, exp2);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    set_a(1'b1, 1'b1, be, addr, data);
    @(negedge clk);
    idle();
    chk("write no valid", {a_v1, a_v2, b_v1, b_v2}, 0);
  endtask

  // Counts rising edges until each instance reports ready; spurious valids are flagged.
  task automatic wait_ready(input string tag, input bit poke);
    int n1 = 0;
    int n2 = 0;
    bit stray = 0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk);
      #1;
      if (a_v1 | b_v1 | a_v2 | b_v2) stray = 1;
      if (rdy1 && n1 == 0) n1 = n;
      if (rdy2 && n2 == 0) n2 = n;
      if (poke && n == 11) begin
        set_a(1'b1, 1'b1, 4'hF, 4'd2, 32'hDEAD_BEEF);
        set_b(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
      end
      if (poke && n == 13) idle();
      if (n1 != 0 && n2 != 0) break;
    end
    chk({tag, " ready edges 1"}, n1, 16);
    chk({tag, " ready edges 2"}, n2, 16);
    chk({tag, " no valid while clearing"}, stray, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk("reset ready", {rdy1, rdy2}, 0);
    chk("reset valid", {a_v1, b_v1, a_v2, b_v2}, 0);
    chk("reset collision", {col1, col2}, 0);
    chk("reset a_data_out", a_do1 | a_do2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("clear", 1'b0);

    for (int i = 0; i < 16; i++) rd("clear word", 1'b0, 4'(i), 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    wr(4'd5, 32'h1122_3344, 4'hF);
    wr(4'd5, 32'hAABB_CCDD, 4'b0101);
    rd("byte enable", 1'b0, 4'd5, 32'h11BB_33DD, 32'h11BB_33DD);

    @(negedge clk);
    set_a(1'b1, 1'b1, 4'hF, 4'd3, 32'h0000_0012);
    set_b(1'b1, 1'b1, 4'hF, 4'd3, 32'h0000_0034);
    @(negedge clk);
    idle();
    chk("collision pulse", {col1, col2}, 2'b11);
    @(negedge clk);
    chk("collision one cycle", {col1, col2}, 0);
    rd("double write", 1'b1, 4'd3, 32'h0000_0012, 32'h0000_0012);

    @(negedge clk);
    set_a(1'b1, 1'b1, 4'b0001, 4'd4, 32'h0000_00AA);
    set_b(1'b1, 1'b1, 4'b0011, 4'd4, 32'hBBBB_BBBB);
    @(negedge clk);
    idle();
    rd("lane merge", 1'b0, 4'd4, 32'hA5A5_BBAA, 32'hA5A5_BBAA);

    @(negedge clk);
    set_a(1'b1, 1'b1, 4'hF, 4'd6, 32'h0000_0001);
    set_b(1'b1, 1'b1, 4'hF, 4'd8, 32'h0000_0002);
    @(negedge clk);
    idle();
    chk("no collision diff addr", {col1, col2}, 0);
    rd("independent a", 1'b0, 4'd6, 32'h1, 32'h1);
    rd("independent b", 1'b1, 4'd8, 32'h2, 32'h2);

    wr(4'd7, 32'h0000_0000, 4'hF);
    @(negedge clk);
    set_a(1'b1, 1'b1, 4'hF, 4'd7, 32'hFFFF_FFFF);
    set_b(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    @(negedge clk);
    idle();
    chk("rdw a no valid", {a_v1, a_v2}, 0);
    chk("rdw old valid", b_v1, 1);
    chk("rdw old data", b_do1, 32'h0000_0000);
    @(negedge clk);
    chk("rdw new valid", b_v2, 1);
    chk("rdw new data", b_do2, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("hold data", b_do1, 32'h0000_0000);
    rd("rdw after", 1'b0, 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset data", a_do1 | a_do2, 0);
    chk("async reset ready", {rdy1, rdy2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-clear reset ready", {rdy1, rdy2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("restart", 1'b1);
    rd("ignored write", 1'b0, 4'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
